// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters; define ALU_ARB_FIXED_PRIORITY_EN for fixed port-0 priority
module alu_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int OP_W      = 4,
    parameter int FLAG_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [1:0]           req_valid,
    input  logic [OP_W-1:0]      req_op0,
    input  logic [OP_W-1:0]      req_op1,
    input  logic [WORD_SIZE-1:0] req_a0,
    input  logic [WORD_SIZE-1:0] req_a1,
    input  logic [WORD_SIZE-1:0] req_b0,
    input  logic [WORD_SIZE-1:0] req_b1,
    output logic [1:0]           req_ready,
    output logic [1:0]           rsp_valid,
    output logic [WORD_SIZE-1:0] rsp_data,
    output logic [FLAG_W-1:0]    rsp_flags,
    output logic [OP_W-1:0]      alu_op,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    input  logic [WORD_SIZE-1:0] alu_out,
    input  logic [FLAG_W-1:0]    alu_flags
);
    localparam logic [OP_W-1:0] ALU_ADD = '0;

    logic [1:0] w_grant;
    logic       w_port;
    logic       w_xfer;
    logic       r_issue_vld;
    logic       r_issue_port;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
    logic       r_last;
`endif

    // grant selection: nothing while stalled or in reset, otherwise priority among valid ports
    always_comb begin
        w_grant = 2'b00;
        if (!stall && !reset) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
            w_grant = req_valid[0] ? 2'b01 : {req_valid[1], 1'b0};
`else
            w_grant = (&req_valid) ? (r_last ? 2'b01 : 2'b10) : req_valid;
`endif
        end
    end

    assign req_ready = w_grant;
    assign w_port    = w_grant[1];
    assign w_xfer    = |w_grant;

    // issue stage: load the granted operation into the ALU registers, which hold when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_op       <= ALU_ADD;
            alu_a        <= '0;
            alu_b        <= '0;
            r_issue_vld  <= 1'b0;
            r_issue_port <= 1'b0;
        end else begin
            r_issue_vld <= w_xfer;
            if (w_xfer) begin
                alu_op       <= w_port ? req_op1 : req_op0;
                alu_a        <= w_port ? req_a1 : req_a0;
                alu_b        <= w_port ? req_b1 : req_b0;
                r_issue_port <= w_port;
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIORITY_EN
    // round-robin pointer: remembers the last granted port, starts at 1 so port 0 wins first
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_last <= 1'b1;
        else if (w_xfer)
            r_last <= w_port;
    end
`endif

    // result stage: capture the ALU output one edge after issue and strobe the owning port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 2'b00;
            rsp_data  <= '0;
            rsp_flags <= '0;
        end else begin
            rsp_valid <= r_issue_vld ? (r_issue_port ? 2'b10 : 2'b01) : 2'b00;
            if (r_issue_vld) begin
                rsp_data  <= alu_out;
                rsp_flags <= alu_flags;
            end
        end
    end
endmodule
